// File: rtl/mem_req_ctrl_if.sv
// Data-bus side of the MEM-stage request engine: req/addr_ok/data_ok handshake plus payload.
interface mem_req_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned NB = DATA_W / 8;

  logic              bus_req;
  logic              bus_wr;
  logic [NB-1:0]     bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// MEM-stage load/store engine: alignment check, strobe/lane shifting, one outstanding
// bus access with req/addr_ok/data_ok handshake, and extended load return.
module mem_req_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_valid,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              ale,
  output logic [DATA_W-1:0] rdata,
  mem_req_ctrl_if.master    bus
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OW   = $clog2(NB);
  localparam bit          DW64 = (DATA_W == 64);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [OW-1:0]   r_off;
  logic [1:0]      r_size;
  logic            r_sext;
  logic            r_store;

  logic [OW-1:0]   off_c;
  logic            bad_c;
  logic [NB-1:0]   base_strb_c;
  logic [NB-1:0]   strb_c;
  logic [DATA_W-1:0] sh_c;
  logic [DATA_W-1:0] mask_c;
  logic            sign_c;
  logic [DATA_W-1:0] ext_c;

  assign off_c = addr[OW-1:0];

  // Misaligned or dword on a 32-bit bus raises ale instead of a bus access
  always_comb begin
    bad_c = 1'b0;
    case (size)
      2'd0:    bad_c = 1'b0;
      2'd1:    bad_c = addr[0];
      2'd2:    bad_c = |addr[1:0];
      default: bad_c = (|addr[2:0]) || !DW64;
    endcase
  end

  always_comb begin
    base_strb_c = '0;
    case (size)
      2'd0:    base_strb_c = NB'(8'h01);
      2'd1:    base_strb_c = NB'(8'h03);
      2'd2:    base_strb_c = NB'(8'h0F);
      default: base_strb_c = NB'(8'hFF);
    endcase
  end

  assign strb_c = base_strb_c << off_c;

  // Load return: shift the addressed lanes down, then sign/zero extend by size
  assign sh_c = bus.bus_rdata >> {r_off, 3'b000};

  always_comb begin
    mask_c = '1;
    sign_c = 1'b0;
    case (r_size)
      2'd0: begin
        mask_c = DATA_W'(8'hFF);
        sign_c = sh_c[7];
      end
      2'd1: begin
        mask_c = DATA_W'(16'hFFFF);
        sign_c = sh_c[15];
      end
      2'd2: begin
        mask_c = DATA_W'(32'hFFFF_FFFF);
        sign_c = sh_c[31];
      end
      default: begin
        mask_c = '1;
        sign_c = 1'b0;
      end
    endcase
  end

  assign ext_c = (sh_c & mask_c) | ((r_sext && sign_c) ? ~mask_c : '0);

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      r_off         <= '0;
      r_size        <= '0;
      r_sext        <= 1'b0;
      r_store       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ale           <= 1'b0;
      rdata         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_wr    <= 1'b0;
      bus.bus_wstrb <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      done <= 1'b0;
      ale  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            r_off   <= off_c;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_store <= is_store;
            if (bad_c) begin
              ale <= 1'b1;
            end else begin
              state         <= REQ;
              busy          <= 1'b1;
              bus.bus_req   <= 1'b1;
              bus.bus_wr    <= is_store;
              bus.bus_wstrb <= is_store ? strb_c : '0;
              bus.bus_addr  <= {addr[ADDR_W-1:OW], {OW{1'b0}}};
              bus.bus_wdata <= wdata << {off_c, 3'b000};
            end
          end
        end
        REQ: begin
          if (bus.bus_addr_ok) begin
            bus.bus_req <= 1'b0;
            if (bus.bus_data_ok) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              rdata <= r_store ? '0 : ext_c;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.bus_data_ok) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            rdata <= r_store ? '0 : ext_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: 32- and 64-bit instances share stimulus; an access-level model
// predicts every output each cycle, and directed literals pin the model.
module tb_mem_req_ctrl;

  logic        clk;
  logic        rstn;
  logic        ex_valid;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [63:0] wd;
  logic [63:0] rd;
  logic        addr_ok;
  logic        data_ok;

  logic        busy32, done32, ale32;
  logic [31:0] rdata32;
  logic        busy64, done64, ale64;
  logic [63:0] rdata64;

  int checks = 0;
  int errors = 0;

  mem_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
  mem_req_ctrl_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

  assign bus32.bus_addr_ok = addr_ok;
  assign bus32.bus_data_ok = data_ok;
  assign bus32.bus_rdata   = rd[31:0];
  assign bus64.bus_addr_ok = addr_ok;
  assign bus64.bus_data_ok = data_ok;
  assign bus64.bus_rdata   = rd;

  mem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut32 (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wd[31:0]), .busy(busy32), .done(done32),
    .ale(ale32), .rdata(rdata32), .bus(bus32.master)
  );

  mem_req_ctrl #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wd), .busy(busy64), .done(done64),
    .ale(ale64), .rdata(rdata64), .bus(bus64.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- access-level reference model (index 0: 32-bit, 1: 64-bit) -------------
  function automatic logic [63:0] dmask(input int i);
    return (i != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int nb_of(input int i);
    return (i != 0) ? 8 : 4;
  endfunction

  function automatic bit bad_acc(input int i, input logic [1:0] sz, input logic [31:0] a);
    return ((a % (32'd1 << sz)) != 32'd0) || (sz == 2'd3 && i == 0);
  endfunction

  function automatic logic [63:0] ext_load(input int i, input int off, input logic [1:0] sz,
                                           input logic sx, input logic [63:0] r);
    logic [63:0] sh;
    logic [63:0] m;
    int          bits;
    sh   = (r & dmask(i)) >> (8 * off);
    bits = 8 << sz;
    if (bits >= 8 * nb_of(i)) return sh;
    m  = (64'd1 << bits) - 64'd1;
    sh = sh & m;
    if (sx && sh[bits-1]) sh = sh | (~m & dmask(i));
    return sh;
  endfunction

  bit          m_pend [2];
  bit          m_acc  [2];
  bit          m_st   [2];
  bit          m_sx   [2];
  logic [1:0]  m_size [2];
  int          m_off  [2];
  logic        e_busy [2];
  logic        e_done [2];
  logic        e_ale  [2];
  logic        e_req  [2];
  logic        e_wr   [2];
  logic [7:0]  e_strb [2];
  logic [31:0] e_addr [2];
  logic [63:0] e_wdata[2];
  logic [63:0] e_rdata[2];

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_pend[i] = 1'b0; m_acc[i] = 1'b0;
        e_busy[i] = 1'b0; e_done[i] = 1'b0; e_ale[i] = 1'b0; e_req[i] = 1'b0;
        e_wr[i] = 1'b0; e_strb[i] = '0; e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
      end else begin
        bit fin;
        fin       = 1'b0;
        e_done[i] = 1'b0;
        e_ale[i]  = 1'b0;
        if (!m_pend[i]) begin
          if (ex_valid) begin
            m_st[i]   = is_store;
            m_sx[i]   = sign_ext;
            m_size[i] = size;
            m_off[i]  = int'(addr % 32'(nb_of(i)));
            if (bad_acc(i, size, addr)) begin
              e_ale[i] = 1'b1;
            end else begin
              m_pend[i]  = 1'b1;
              m_acc[i]   = 1'b0;
              e_busy[i]  = 1'b1;
              e_req[i]   = 1'b1;
              e_wr[i]    = is_store;
              e_strb[i]  = is_store ?
                8'((((32'd1 << (32'd1 << size)) - 32'd1) << m_off[i]) &
                   ((32'd1 << nb_of(i)) - 32'd1)) : 8'h00;
              e_addr[i]  = addr - 32'(m_off[i]);
              e_wdata[i] = ((wd & dmask(i)) << (8 * m_off[i])) & dmask(i);
            end
          end
        end else if (!m_acc[i]) begin
          if (addr_ok) begin
            e_req[i] = 1'b0;
            if (data_ok) fin = 1'b1;
            else m_acc[i] = 1'b1;
          end
        end else if (data_ok) begin
          fin = 1'b1;
        end
        if (fin) begin
          m_pend[i]  = 1'b0;
          e_busy[i]  = 1'b0;
          e_done[i]  = 1'b1;
          e_rdata[i] = m_st[i] ? 64'd0 : ext_load(i, m_off[i], m_size[i], m_sx[i], rd);
        end
      end
    end
  end

  task automatic cmp_inst(input string p, input int i, input logic b, input logic d,
                          input logic a, input logic rq, input logic w, input logic [7:0] st,
                          input logic [31:0] ad, input logic [63:0] wdt, input logic [63:0] rdt);
    check({p, ".busy"}, 64'(b), 64'(e_busy[i]));
    check({p, ".done"}, 64'(d), 64'(e_done[i]));
    check({p, ".ale"},  64'(a), 64'(e_ale[i]));
    check({p, ".req"},  64'(rq), 64'(e_req[i]));
    if (e_req[i] || !rstn) begin
      check({p, ".wr"},    64'(w),  64'(e_wr[i]));
      check({p, ".wstrb"}, 64'(st), 64'(e_strb[i]));
      check({p, ".addr"},  64'(ad), 64'(e_addr[i]));
      check({p, ".wdata"}, wdt,     e_wdata[i]);
    end
    if (e_done[i] || !rstn) check({p, ".rdata"}, rdt, e_rdata[i]);
  endtask

  // Single compare process: every cycle, on the falling edge
  always @(negedge clk) begin
    cmp_inst("d32", 0, busy32, done32, ale32, bus32.bus_req, bus32.bus_wr,
             8'(bus32.bus_wstrb), bus32.bus_addr, 64'(bus32.bus_wdata), 64'(rdata32));
    cmp_inst("d64", 1, busy64, done64, ale64, bus64.bus_req, bus64.bus_wr,
             bus64.bus_wstrb, bus64.bus_addr, bus64.bus_wdata, rdata64);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ex(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [63:0] w);
    is_store = st; size = sz; sign_ext = sx; addr = a; wd = w;
    ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; ex_valid = 1'b0; is_store = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wd = '0; rd = '0; addr_ok = 1'b0; data_ok = 1'b0;
    repeat (3) cyc();
    check("rst.busy32", 64'(busy32), 64'd0);
    check("rst.req64",  64'(bus64.bus_req), 64'd0);
    check("rst.rdata64", rdata64, 64'd0);
    rstn = 1'b1;
    cyc();

    // byte store at lane 3
    drive_ex(1'b1, 2'd0, 1'b0, 32'h1003, 64'hAB);
    check("st.req",   64'(bus32.bus_req), 64'd1);
    check("st.wr",    64'(bus32.bus_wr), 64'd1);
    check("st.wstrb", 64'(bus32.bus_wstrb), 64'h8);
    check("st.addr",  64'(bus32.bus_addr), 64'h1000);
    check("st.wbyte", 64'(bus32.bus_wdata[31:24]), 64'hAB);
    addr_ok = 1'b1; cyc(); addr_ok = 1'b0;
    check("st.reqdrop", 64'(bus32.bus_req), 64'd0);
    data_ok = 1'b1; cyc(); data_ok = 1'b0;
    check("st.done",  64'(done32), 64'd1);
    check("st.rdata", 64'(rdata32), 64'd0);
    cyc();
    check("st.done1", 64'(done32), 64'd0);

    // half loads, sign- and zero-extended
    for (int k = 0; k < 2; k++) begin
      drive_ex(1'b0, 2'd1, (k == 0), 32'h2002, 64'h0);
      addr_ok = 1'b1; cyc(); addr_ok = 1'b0;
      cyc();
      rd = 64'h0000_0000_8001_1234; data_ok = 1'b1; cyc(); data_ok = 1'b0;
      check("ldh.done", 64'(done32), 64'd1);
      check("ldh.rdata32", 64'(rdata32), (k == 0) ? 64'hFFFF_8001 : 64'h0000_8001);
      check("ldh.rdata64", rdata64, (k == 0) ? 64'hFFFF_FFFF_FFFF_8001 : 64'h8001);
      cyc();
    end

    // misaligned word load
    drive_ex(1'b0, 2'd2, 1'b0, 32'h2001, 64'h0);
    check("ale.ale",  64'(ale32), 64'd1);
    check("ale.req",  64'(bus32.bus_req), 64'd0);
    check("ale.busy", 64'(busy32), 64'd0);
    cyc();
    check("ale.pulse", 64'(ale32), 64'd0);
    check("ale.req1",  64'(bus32.bus_req), 64'd0);

    // addr_ok withheld 5 cycles, then addr_ok+data_ok together
    drive_ex(1'b0, 2'd2, 1'b1, 32'h3000, 64'h0);
    repeat (5) cyc();
    check("hold.req",  64'(bus32.bus_req), 64'd1);
    check("hold.addr", 64'(bus32.bus_addr), 64'h3000);
    rd = 64'h1122_3344_5566_7788; addr_ok = 1'b1; data_ok = 1'b1; cyc();
    addr_ok = 1'b0; data_ok = 1'b0;
    check("fast.done",    64'(done32), 64'd1);
    check("fast.rdata32", 64'(rdata32), 64'h5566_7788);
    check("fast.rdata64", rdata64, 64'h5566_7788);
    cyc();

    // ex_valid while busy is ignored; ex_valid in the done cycle starts a new access
    drive_ex(1'b1, 2'd1, 1'b0, 32'h4002, 64'h1234);
    drive_ex(1'b0, 2'd0, 1'b0, 32'h5000, 64'h0);
    check("ign.addr", 64'(bus32.bus_addr), 64'h4000);
    check("ign.wstrb", 64'(bus32.bus_wstrb), 64'hC);
    addr_ok = 1'b1; cyc(); addr_ok = 1'b0;
    data_ok = 1'b1; cyc(); data_ok = 1'b0;
    check("b2b.done", 64'(done32), 64'd1);
    drive_ex(1'b0, 2'd0, 1'b1, 32'h6001, 64'h0);
    check("b2b.req",  64'(bus32.bus_req), 64'd1);
    check("b2b.addr", 64'(bus32.bus_addr), 64'h6000);
    rd = 64'h0000_0000_0000_8000; addr_ok = 1'b1; data_ok = 1'b1; cyc();
    addr_ok = 1'b0; data_ok = 1'b0;
    check("ldb.rdata32", 64'(rdata32), 64'hFFFF_FF80);
    check("ldb.rdata64", rdata64, 64'hFFFF_FFFF_FFFF_FF80);
    cyc();

    // dword load: illegal on 32-bit, passthrough on 64-bit
    drive_ex(1'b0, 2'd3, 1'b0, 32'h8, 64'h0);
    check("dw.ale32", 64'(ale32), 64'd1);
    check("dw.req32", 64'(bus32.bus_req), 64'd0);
    check("dw.req64", 64'(bus64.bus_req), 64'd1);
    rd = 64'h0123_4567_89AB_CDEF; addr_ok = 1'b1; cyc(); addr_ok = 1'b0;
    data_ok = 1'b1; cyc(); data_ok = 1'b0;
    check("dw.rdata64", rdata64, 64'h0123_4567_89AB_CDEF);
    cyc();

    // word store on upper lanes, then reset while waiting for data_ok
    drive_ex(1'b1, 2'd2, 1'b0, 32'hC, 64'hDEAD_BEEF);
    check("sw.wstrb64", 64'(bus64.bus_wstrb), 64'hF0);
    check("sw.wdata64", bus64.bus_wdata, 64'hDEAD_BEEF_0000_0000);
    check("sw.addr64",  64'(bus64.bus_addr), 64'h8);
    check("sw.wstrb32", 64'(bus32.bus_wstrb), 64'hF);
    addr_ok = 1'b1; cyc(); addr_ok = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst.busy64", 64'(busy64), 64'd0);
    check("rst.req64w", 64'(bus64.bus_req), 64'd0);
    check("rst.wstrb64", 64'(bus64.bus_wstrb), 64'd0);
    check("rst.wdata64", bus64.bus_wdata, 64'd0);
    cyc();
    rstn = 1'b1;
    data_ok = 1'b1; cyc(); data_ok = 1'b0;
    check("rst.nodone64", 64'(done64), 64'd0);
    check("rst.nodone32", 64'(done32), 64'd0);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
